// File: rtl/fir_coeff_axi_wr.sv
// AXI4-Lite write responder for the 2D FIR coefficient bank: CPU writes go to a shadow bank,
// and a CTRL commit copies it to the active bank on the next frame start. Optional FIR_COEFF_WSTRB_EN honours byte strobes.
module fir_coeff_axi_wr #(
   parameter int unsigned ADDR_BITS = 10,
   parameter int unsigned NUM_COEF  = 25,
   parameter int unsigned COEF_W    = 16,
   parameter logic [COEF_W-1:0] CENTER_RST = COEF_W'(16'h0100)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [31:0]                  s_axi_awaddr,
   input  logic                         s_axi_awvalid,
   output logic                         s_axi_awready,
   input  logic [31:0]                  s_axi_wdata,
   input  logic [3:0]                   s_axi_wstrb,
   input  logic                         s_axi_wvalid,
   output logic                         s_axi_wready,
   output logic [1:0]                   s_axi_bresp,
   output logic                         s_axi_bvalid,
   input  logic                         s_axi_bready,
   input  logic                         vs_i,
   output logic [NUM_COEF*COEF_W-1:0]   coeff_o,
   output logic                         coeff_update_o,
   output logic                         commit_pending_o
);

   localparam int unsigned IDX_W = ADDR_BITS - 2;
   localparam int unsigned NB    = COEF_W / 8;
   localparam logic [IDX_W-1:0] CTRL_IDX = IDX_W'(NUM_COEF);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;

   state_t state, state_n;

   logic              aw_full, aw_full_n;
   logic              w_full, w_full_n;
   logic [IDX_W-1:0]  aw_idx;
   logic [COEF_W-1:0] w_data;
   logic [3:0]        w_strb;
   logic              awready_n, wready_n, bvalid_n;
   logic [1:0]        bresp_n;
   logic              aw_hs, w_hs;
   logic              do_write, is_coef, is_ctrl, ctrl_set;
   logic              vs_q, vs_rise, commit_fire;
   logic [NB-1:0]     lane_en;
   logic              unused_bits;

   logic [NUM_COEF-1:0][COEF_W-1:0] shadow;
   logic [NUM_COEF-1:0][COEF_W-1:0] active;

   assign aw_hs    = s_axi_awvalid && s_axi_awready;
   assign w_hs     = s_axi_wvalid && s_axi_wready;
   assign do_write = (state == WRITE);
   assign is_coef  = (aw_idx < CTRL_IDX);
   assign is_ctrl  = (aw_idx == CTRL_IDX);
   assign vs_rise  = vs_i && !vs_q;
   // A CTRL write landing on a frame edge arms the commit for the following edge instead.
   assign commit_fire = vs_rise && commit_pending_o && !ctrl_set;
   assign coeff_o  = active;

`ifdef FIR_COEFF_WSTRB_EN
   assign lane_en  = w_strb[NB-1:0];
   assign ctrl_set = do_write && is_ctrl && w_data[0] && w_strb[0];
   assign unused_bits = ^{s_axi_awaddr[31:ADDR_BITS], s_axi_awaddr[1:0],
                          s_axi_wdata[31:COEF_W], w_strb[3:NB]};
`else
   assign lane_en  = '1;
   assign ctrl_set = do_write && is_ctrl && w_data[0];
   assign unused_bits = ^{s_axi_awaddr[31:ADDR_BITS], s_axi_awaddr[1:0],
                          s_axi_wdata[31:COEF_W], w_strb};
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next state, buffer occupancy and registered handshake outputs
   always_comb begin
      state_n   = state;
      aw_full_n = aw_full;
      w_full_n  = w_full;
      bresp_n   = s_axi_bresp;
      case (state)
         IDLE: begin
            if (aw_hs) aw_full_n = 1'b1;
            if (w_hs)  w_full_n  = 1'b1;
            if (aw_full && w_full) state_n = WRITE;
         end
         WRITE: begin
            aw_full_n = 1'b0;
            w_full_n  = 1'b0;
            bresp_n   = (is_coef || is_ctrl) ? RESP_OKAY : RESP_SLVERR;
            state_n   = RESP;
         end
         RESP: begin
            if (s_axi_bvalid && s_axi_bready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      awready_n = (state_n == IDLE) && !aw_full_n;
      wready_n  = (state_n == IDLE) && !w_full_n;
      bvalid_n  = (state_n == RESP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_axi_awready <= 1'b0;
         s_axi_wready  <= 1'b0;
         s_axi_bvalid  <= 1'b0;
         s_axi_bresp   <= RESP_OKAY;
         aw_full       <= 1'b0;
         w_full        <= 1'b0;
         aw_idx        <= '0;
         w_data        <= '0;
         w_strb        <= '0;
      end else begin
         s_axi_awready <= awready_n;
         s_axi_wready  <= wready_n;
         s_axi_bvalid  <= bvalid_n;
         s_axi_bresp   <= bresp_n;
         aw_full       <= aw_full_n;
         w_full        <= w_full_n;
         if (aw_hs) aw_idx <= s_axi_awaddr[ADDR_BITS-1:2];
         if (w_hs) begin
            w_data <= s_axi_wdata[COEF_W-1:0];
            w_strb <= s_axi_wstrb;
         end
      end
   end

   // Frame-edge detect and commit handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         vs_q             <= 1'b0;
         commit_pending_o <= 1'b0;
         coeff_update_o   <= 1'b0;
      end else begin
         vs_q           <= vs_i;
         coeff_update_o <= commit_fire;
         if (ctrl_set)         commit_pending_o <= 1'b1;
         else if (commit_fire) commit_pending_o <= 1'b0;
      end
   end

   // Coefficient banks; active copies the shadow contents from before any same-cycle write
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < NUM_COEF; k++) begin
            shadow[k] <= (k == NUM_COEF / 2) ? CENTER_RST : '0;
            active[k] <= (k == NUM_COEF / 2) ? CENTER_RST : '0;
         end
      end else begin
         if (commit_fire) active <= shadow;
         if (do_write && is_coef) begin
            for (int unsigned k = 0; k < NUM_COEF; k++) begin
               for (int unsigned b = 0; b < NB; b++) begin
                  if (aw_idx == IDX_W'(k) && lane_en[b])
                     shadow[k][8*b +: 8] <= w_data[8*b +: 8];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_fir_coeff_axi_wr.sv
// Directed bench for fir_coeff_axi_wr: handshakes, decode, commit timing and frame-edge corner cases.
module tb_fir_coeff_axi_wr;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  awaddr;
   logic         awvalid;
   logic         awready;
   logic [31:0]  wdata;
   logic [3:0]   wstrb;
   logic         wvalid;
   logic         wready;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready;
   logic         vs;
   logic [399:0] coeff;
   logic         upd;
   logic         pend;

   int total = 0;
   int bad   = 0;

   fir_coeff_axi_wr dut (
      .clk              (clk),
      .rst              (rst),
      .s_axi_awaddr     (awaddr),
      .s_axi_awvalid    (awvalid),
      .s_axi_awready    (awready),
      .s_axi_wdata      (wdata),
      .s_axi_wstrb      (wstrb),
      .s_axi_wvalid     (wvalid),
      .s_axi_wready     (wready),
      .s_axi_bresp      (bresp),
      .s_axi_bvalid     (bvalid),
      .s_axi_bready     (bready),
      .vs_i             (vs),
      .coeff_o          (coeff),
      .coeff_update_o   (upd),
      .commit_pending_o (pend)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] tap(input int k);
      return {16'h0, coeff[k*16 +: 16]};
   endfunction

   // One AXI write; W is presented first and AW follows aw_lag cycles later (0 = same cycle)
   task automatic axi_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input int aw_lag, input int b_delay, input bit vs_hit,
                         output logic [1:0] resp, output int lat,
                         output logic held_bvalid, output logic held_rdy, output logic upd_at_b);
      bit aw_pend, w_pend, aw_go, w_go;
      int cyc;
      @(negedge clk);
      awaddr = addr;
      wdata  = data;
      wstrb  = strb;
      wvalid = 1'b1;
      awvalid = (aw_lag == 0);
      aw_pend = 1'b1;
      w_pend  = 1'b1;
      cyc     = 0;
      while ((aw_pend || w_pend) && cyc < 30) begin
         aw_go = awvalid && awready;
         w_go  = wvalid && wready;
         @(negedge clk);
         cyc++;
         if (aw_go) begin awvalid = 1'b0; aw_pend = 1'b0; end
         if (w_go)  begin wvalid  = 1'b0; w_pend  = 1'b0; end
         if (aw_pend && !awvalid && cyc >= aw_lag) awvalid = 1'b1;
      end
      chk("hs_done", 32'(aw_pend || w_pend), 32'd0);
      lat = 0;
      while (!bvalid && lat < 20) begin
         @(negedge clk);
         lat++;
         if (vs_hit && lat == 1) vs = 1'b1;
      end
      chk("b_seen", 32'(bvalid), 32'd1);
      resp     = bresp;
      upd_at_b = upd;
      repeat (b_delay) @(negedge clk);
      held_bvalid = bvalid;
      held_rdy    = awready | wready;
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      chk("b_drop", 32'(bvalid), 32'd0);
   endtask

   task automatic vs_pulse(output logic u1, output logic u2);
      @(negedge clk);
      vs = 1'b1;
      @(negedge clk);
      u1 = upd;
      @(negedge clk);
      u2 = upd;
      vs = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [1:0] r;
      int         lat;
      logic       hb, hr, ub, u1, u2;

      rst = 1'b1; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = 4'hF;
      wvalid = 1'b0; bready = 1'b0; vs = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_awready", 32'(awready), 32'd0);
      chk("rst_wready",  32'(wready),  32'd0);
      chk("rst_bvalid",  32'(bvalid),  32'd0);
      chk("rst_bresp",   32'(bresp),   32'd0);
      chk("rst_update",  32'(upd),     32'd0);
      chk("rst_pending", 32'(pend),    32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_awready", 32'(awready), 32'd1);
      chk("post_wready",  32'(wready),  32'd1);
      chk("rst_tap12", tap(12), 32'h0100);
      chk("rst_tap0",  tap(0),  32'h0);
      chk("rst_tap24", tap(24), 32'h0);

      // Same-cycle AW/W: bvalid two cycles after acceptance, active unchanged
      axi_wr(32'h00, 32'h0000FFF0, 4'hF, 0, 0, 0, r, lat, hb, hr, ub);
      chk("t2_lat",  32'(lat), 32'd2);
      chk("t2_resp", 32'(r),   32'd0);
      chk("t2_tap0", tap(0),   32'h0);
      chk("t2_pend", 32'(pend), 32'd0);

      // W first, AW three cycles later; then commit on a frame edge
      axi_wr(32'h30, 32'h7, 4'hF, 3, 0, 0, r, lat, hb, hr, ub);
      chk("t3_lat",  32'(lat), 32'd2);
      chk("t3_resp", 32'(r),   32'd0);
      axi_wr(32'h64, 32'h1, 4'hF, 0, 0, 0, r, lat, hb, hr, ub);
      chk("t3_ctrl_resp", 32'(r), 32'd0);
      chk("t3_pend_set",  32'(pend), 32'd1);
      chk("t3_tap12_pre", tap(12), 32'h0100);
      vs_pulse(u1, u2);
      chk("t3_upd_hi",  32'(u1), 32'd1);
      chk("t3_upd_lo",  32'(u2), 32'd0);
      chk("t3_tap12",   tap(12), 32'h0007);
      chk("t3_tap0",    tap(0),  32'hFFF0);
      chk("t3_pend_clr", 32'(pend), 32'd0);

      // CTRL write with bit0 clear leaves commit idle
      axi_wr(32'h64, 32'h0, 4'hF, 0, 0, 0, r, lat, hb, hr, ub);
      chk("ctrl0_resp", 32'(r), 32'd0);
      chk("ctrl0_pend", 32'(pend), 32'd0);

      // Out-of-range address with a stalled response channel
      axi_wr(32'h68, 32'h55, 4'hF, 0, 5, 0, r, lat, hb, hr, ub);
      chk("t4_resp",   32'(r),  32'd2);
      chk("t4_bhold",  32'(hb), 32'd1);
      chk("t4_rdy_lo", 32'(hr), 32'd0);
      chk("t4_pend",   32'(pend), 32'd0);
      chk("t4_tap12",  tap(12), 32'h0007);

      // CTRL write coinciding with a frame edge waits for the next edge
      axi_wr(32'h04, 32'h11, 4'hF, 0, 0, 0, r, lat, hb, hr, ub);
      axi_wr(32'h64, 32'h1, 4'hF, 0, 0, 1, r, lat, hb, hr, ub);
      vs = 1'b0;
      chk("t5_no_upd",  32'(ub), 32'd0);
      chk("t5_pend",    32'(pend), 32'd1);
      chk("t5_tap1_old", tap(1), 32'h0);
      @(negedge clk);
      axi_wr(32'h64, 32'h1, 4'hF, 0, 0, 0, r, lat, hb, hr, ub);
      chk("t5_pend_rep", 32'(pend), 32'd1);
      vs_pulse(u1, u2);
      chk("t5_upd",     32'(u1), 32'd1);
      chk("t5_tap1",    tap(1), 32'h0011);
      chk("t5_pend_clr", 32'(pend), 32'd0);
      vs_pulse(u1, u2);
      chk("t5_single_reload", 32'(u1), 32'd0);

      // Byte strobes (honoured only with FIR_COEFF_WSTRB_EN)
      axi_wr(32'h00, 32'h1234, 4'hF, 0, 0, 0, r, lat, hb, hr, ub);
      axi_wr(32'h02, 32'hABCD, 4'b0001, 0, 0, 0, r, lat, hb, hr, ub);
      axi_wr(32'h408, 32'h5555, 4'b0000, 0, 0, 0, r, lat, hb, hr, ub);
      chk("t6_strb0_resp", 32'(r), 32'd0);
      axi_wr(32'h64, 32'h1, 4'hF, 0, 0, 0, r, lat, hb, hr, ub);
      vs_pulse(u1, u2);
      chk("t6_upd", 32'(u1), 32'd1);
`ifdef FIR_COEFF_WSTRB_EN
      chk("t6_tap0", tap(0), 32'h12CD);
      chk("t6_tap2", tap(2), 32'h0);
`else
      chk("t6_tap0", tap(0), 32'hABCD);
      chk("t6_tap2", tap(2), 32'h5555);
`endif
      chk("t6_tap12", tap(12), 32'h0007);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
